// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI command encoder.
// The encoder's OMNI_EN build option does not affect this package.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT  = 4'hA;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CH_AT    = 4'hD;
  localparam logic [3:0] MIDI_PITCH    = 4'hE;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  localparam logic [15:0] CMD_IDLE        = 16'h0000;
  localparam logic [15:0] CMD_STOP_ALL    = 16'h7F00;
  localparam logic [15:0] CMD_CHANGE_WAVE = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_D1,
    ST_WAIT_D2,
    ST_SYSEX,
    ST_SKIP
  } midi_state_e;

  typedef enum logic [2:0] {
    BC_DATA,
    BC_CHANNEL,
    BC_SYSEX,
    BC_COMMON,
    BC_REALTIME
  } byte_class_e;

endpackage

// File: rtl/midi_status_classify.sv
// Combinational byte classifier: class of a MIDI byte and, for channel
// status bytes, how many data bytes complete the message.
module midi_status_classify
  import midi_pkg::*;
(
  input  logic [7:0]  byte_i,
  output byte_class_e class_o,
  output logic [1:0]  data_cnt_o
);

  always_comb begin
    class_o    = BC_DATA;
    data_cnt_o = 2'd0;
    if (!byte_i[7]) begin
      class_o = BC_DATA;
    end else if (byte_i < 8'hF0) begin
      class_o    = BC_CHANNEL;
      data_cnt_o = (byte_i[7:4] == MIDI_PROG || byte_i[7:4] == MIDI_CH_AT) ? 2'd1 : 2'd2;
    end else if (byte_i == 8'hF0) begin
      class_o = BC_SYSEX;
    end else if (byte_i < 8'hF8) begin
      class_o = BC_COMMON;
    end else begin
      class_o = BC_REALTIME;
    end
  end

endmodule

// File: rtl/midi_cmd_encoder.sv
// MIDI byte stream to one-cycle 16-bit bank-manager command words.
// Build option: define OMNI_EN to encode all 16 channels (CHANNEL then unused).
//
// state      | meaning
// IDLE       | no running status, data ignored
// WAIT_D1    | running status valid, awaiting first data byte
// WAIT_D2    | first data byte held, awaiting second
// SYSEX      | inside SysEx, data ignored until a status byte
// SKIP       | after system common, data ignored until a status byte
module midi_cmd_encoder
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_drop
);

  midi_state_e state_q;
  logic [7:0]  status_q;
  logic        two_q;
  logic [6:0]  d1_q;
  logic [15:0] data_q;
  logic        valid_q;
  logic        drop_q;

  byte_class_e cls;
  logic [1:0]  cnt;
  logic        done;
  logic [6:0]  key;
  logic [6:0]  vel;
  logic        ch_match;
  logic [15:0] cmd_d;
  logic        valid_d;
  logic        drop_d;

  midi_status_classify u_classify (
    .byte_i     (i_byte),
    .class_o    (cls),
    .data_cnt_o (cnt)
  );

`ifdef OMNI_EN
  assign ch_match = 1'b1;
`else
  assign ch_match = (status_q[3:0] == CHANNEL);
`endif

  // Message completion and its encoding, evaluated on the accepting cycle.
  always_comb begin
    done = 1'b0;
    key  = '0;
    vel  = '0;
    if (i_byte_valid && cls == BC_DATA) begin
      if (state_q == ST_WAIT_D1 && !two_q) begin
        done = 1'b1;
        key  = i_byte[6:0];
      end else if (state_q == ST_WAIT_D2) begin
        done = 1'b1;
        key  = d1_q;
        vel  = i_byte[6:0];
      end
    end

    cmd_d   = CMD_IDLE;
    valid_d = 1'b0;
    drop_d  = 1'b0;
    if (done && ch_match) begin
      case (status_q[7:4])
        MIDI_NOTE_ON, MIDI_NOTE_OFF: begin
          // Note 0 marks a free bank slot; note 127 off would alias STOP_ALL.
          if (key == 7'd0 || key == 7'd127) begin
            drop_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            cmd_d   = (status_q[7:4] == MIDI_NOTE_ON && vel != 7'd0) ?
                      {1'b1, key, 1'b0, vel} : {1'b0, key, 8'h00};
          end
        end
        MIDI_CC: begin
          if (key == CC_ALL_SOUND_OFF || key == CC_ALL_NOTES_OFF) begin
            valid_d = 1'b1;
            cmd_d   = CMD_STOP_ALL;
          end
        end
        MIDI_PROG: begin
          valid_d = 1'b1;
          cmd_d   = CMD_CHANGE_WAVE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      status_q <= 8'h00;
      two_q    <= 1'b0;
      d1_q     <= '0;
      data_q   <= CMD_IDLE;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      data_q  <= cmd_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      if (i_byte_valid) begin
        case (cls)
          BC_REALTIME: ;
          BC_CHANNEL: begin
            status_q <= i_byte;
            two_q    <= (cnt == 2'd2);
            state_q  <= ST_WAIT_D1;
          end
          BC_SYSEX: begin
            status_q <= 8'h00;
            state_q  <= ST_SYSEX;
          end
          BC_COMMON: begin
            status_q <= 8'h00;
            state_q  <= (state_q == ST_SYSEX && i_byte == 8'hF7) ? ST_IDLE : ST_SKIP;
          end
          default: begin
            case (state_q)
              ST_WAIT_D1: begin
                if (two_q) begin
                  d1_q    <= i_byte[6:0];
                  state_q <= ST_WAIT_D2;
                end
              end
              ST_WAIT_D2: state_q <= ST_WAIT_D1;
              default: ;
            endcase
          end
        endcase
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_drop  = drop_q;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Self-checking bench for midi_cmd_encoder: directed vector table, a few
// multi-cycle sequences, and random bytes against a queue-based message model.
module tb_midi_cmd_encoder;

  localparam logic [3:0] CH = 4'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  midi_cmd_encoder #(.CHANNEL(CH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_drop       (o_drop)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic [15:0] data;
    logic        valid;
    logic        drop;
  } vec_t;

  vec_t vecs[$];

  // Reference model: running status byte (-1 when none) and collected data bytes.
  int rs = -1;
  int q[$];

  function automatic bit model_match(int status);
`ifdef OMNI_EN
    return 1'b1;
`else
    return (status % 16) == int'(CH);
`endif
  endfunction

  task automatic model_reset();
    rs = -1;
    q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [15:0] ed,
                            output logic ev, output logic edr);
    int typ, need, k, vel;
    ed = 16'h0000; ev = 1'b0; edr = 1'b0;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      q.delete();
      rs = (b < 8'hF0) ? int'(b) : -1;
      return;
    end
    if (rs < 0) return;
    q.push_back(int'(b));
    typ  = rs / 16;
    need = (typ == 12 || typ == 13) ? 1 : 2;
    if (q.size() < need) return;
    k   = q[0];
    vel = (need == 2) ? q[1] : 0;
    q.delete();
    if (!model_match(rs)) return;
    if (typ == 8 || typ == 9) begin
      if (k == 0 || k == 127) edr = 1'b1;
      else begin
        ev = 1'b1;
        ed = (typ == 9 && vel != 0) ? 16'(32768 + k * 256 + vel) : 16'(k * 256);
      end
    end else if (typ == 11 && (k == 120 || k == 123)) begin
      ev = 1'b1; ed = 16'h7F00;
    end else if (typ == 12) begin
      ev = 1'b1; ed = 16'h8000;
    end
  endtask

  task automatic add(logic v, logic [7:0] b, logic [15:0] d, logic ev, logic edr);
    vec_t t;
    t.vld = v; t.b = b; t.data = d; t.valid = ev; t.drop = edr;
    vecs.push_back(t);
  endtask

  task automatic drive(logic v, logic [7:0] b);
    @(negedge clk);
    i_byte_valid = v;
    i_byte       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [15:0] ed, logic ev, logic edr);
    checks++;
    if (o_data !== ed || o_valid !== ev || o_drop !== edr) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b drop=%b, want data=%h valid=%b drop=%b",
               name, o_data, o_valid, o_drop, ed, ev, edr);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    i_byte_valid = 1'b0;
    #2;
    check("reset_outputs", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] ed;
    logic        ev, edr;
    logic [15:0] omni_note;

`ifdef OMNI_EN
    omni_note = 16'hBC64;
`else
    omni_note = 16'h0000;
`endif

    add(1, 8'h90, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h64, 16'hBC64, 1, 0);  add(0, 8'h00, 16'h0000, 0, 0);
    add(1, 8'h3E, 16'h0000, 0, 0);  add(1, 8'h00, 16'h3E00, 1, 0);
    add(1, 8'h90, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'hF8, 16'h0000, 0, 0);  add(1, 8'h64, 16'hBC64, 1, 0);
    add(1, 8'hB0, 16'h0000, 0, 0);  add(1, 8'h7B, 16'h0000, 0, 0);
    add(1, 8'h00, 16'h7F00, 1, 0);  add(1, 8'h78, 16'h0000, 0, 0);
    add(1, 8'h11, 16'h7F00, 1, 0);
    add(1, 8'hC0, 16'h0000, 0, 0);  add(1, 8'h05, 16'h8000, 1, 0);
    add(1, 8'h06, 16'h8000, 1, 0);
    add(1, 8'hB0, 16'h0000, 0, 0);  add(1, 8'h07, 16'h0000, 0, 0);
    add(1, 8'h40, 16'h0000, 0, 0);
    add(1, 8'h90, 16'h0000, 0, 0);  add(1, 8'h00, 16'h0000, 0, 0);
    add(1, 8'h40, 16'h0000, 0, 1);
    add(1, 8'h80, 16'h0000, 0, 0);  add(1, 8'h7F, 16'h0000, 0, 0);
    add(1, 8'h00, 16'h0000, 0, 1);  add(0, 8'h00, 16'h0000, 0, 0);
    add(1, 8'hF0, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h64, 16'h0000, 0, 0);  add(1, 8'hF7, 16'h0000, 0, 0);
    add(1, 8'h3C, 16'h0000, 0, 0);  add(1, 8'h64, 16'h0000, 0, 0);
    add(1, 8'h91, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h64, omni_note, omni_note != 16'h0000, 0);
    add(1, 8'h90, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h80, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h40, 16'h3C00, 1, 0);
    add(1, 8'hF1, 16'h0000, 0, 0);  add(1, 8'h3C, 16'h0000, 0, 0);
    add(1, 8'h40, 16'h0000, 0, 0);
    add(1, 8'hE0, 16'h0000, 0, 0);  add(1, 8'h01, 16'h0000, 0, 0);
    add(1, 8'h02, 16'h0000, 0, 0);  add(1, 8'hD0, 16'h0000, 0, 0);
    add(1, 8'h05, 16'h0000, 0, 0);  add(1, 8'h90, 16'h0000, 0, 0);
    add(1, 8'h7E, 16'h0000, 0, 0);  add(1, 8'h7F, 16'hFE7F, 1, 0);

    reset = 1'b1;
    i_byte = 8'h00;
    i_byte_valid = 1'b0;
    #1;
    check("reset_async", 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].b);
      check($sformatf("vec%0d_%h", i, vecs[i].b), vecs[i].data, vecs[i].valid, vecs[i].drop);
    end

    // Partial message discarded by reset; trailing data needs a new status.
    drive(1, 8'h90); drive(1, 8'h3C);
    pulse_reset();
    drive(1, 8'h64);
    check("after_reset_data", 16'h0000, 1'b0, 1'b0);
    drive(0, 8'h00);
    check("after_reset_idle", 16'h0000, 1'b0, 1'b0);

    // Idle gaps between bytes hold the partial message.
    drive(1, 8'h90); drive(0, 8'h55); drive(1, 8'h3C); drive(0, 8'h7F); drive(0, 8'h00);
    check("gap_hold", 16'h0000, 1'b0, 1'b0);
    drive(1, 8'h64);
    check("gap_note", 16'hBC64, 1'b1, 1'b0);
    drive(0, 8'h00);
    check("gap_return_idle", 16'h0000, 1'b0, 1'b0);

    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      logic       v;
      int         r;
      r = $urandom_range(0, 99);
      if (r < 22) begin
        case ($urandom_range(0, 6))
          0: b = 8'h80; 1: b = 8'h90; 2: b = 8'h90; 3: b = 8'hB0;
          4: b = 8'hC0; 5: b = 8'hD0; default: b = 8'hE0;
        endcase
        b[0] = ($urandom_range(0, 3) == 0);
      end else if (r < 28) begin
        case ($urandom_range(0, 4))
          0: b = 8'hF0; 1: b = 8'hF7; 2: b = 8'hF1; 3: b = 8'hF8; default: b = 8'hFE;
        endcase
      end else begin
        case ($urandom_range(0, 7))
          0: b = 8'h00; 1: b = 8'h7F; 2: b = 8'd120; 3: b = 8'd123;
          default: b = 8'($urandom_range(0, 127));
        endcase
      end
      v = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end
      drive(v, b);
      if (v) model_byte(b, ed, ev, edr);
      else begin ed = 16'h0000; ev = 1'b0; edr = 1'b0; end
      check($sformatf("rand%0d_%h", n, b), ed, ev, edr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
